// File: rtl/pmp_serial_checker_if.sv
// Request/response bundle between the MMU request path (master) and the
// serial PMP checker (slave).
interface pmp_serial_checker_if #(
  parameter int unsigned PA_BITS     = 56,
  parameter int unsigned PMP_ENTRIES = 16
);
  localparam int unsigned IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;

  logic               ReqValid;
  logic               ReqReady;
  logic [PA_BITS-1:0] ReqAdr;
  logic [1:0]         ReqPriv;
  logic [2:0]         ReqAcc;
  logic               Flush;
  logic               RspValid;
  logic               RspReady;
  logic               RspMatch;
  logic [IDX_W-1:0]   RspIdx;
  logic               RspFault;

  modport master (
    output ReqValid, ReqAdr, ReqPriv, ReqAcc, Flush, RspReady,
    input  ReqReady, RspValid, RspMatch, RspIdx, RspFault
  );

  modport slave (
    input  ReqValid, ReqAdr, ReqPriv, ReqAcc, Flush, RspReady,
    output ReqReady, RspValid, RspMatch, RspIdx, RspFault
  );
endinterface

// File: rtl/pmp_serial_checker.sv
// Serial PMP checker: one TOR/NA4/NAPOT matcher walks the entries lowest index first.
// Optional macro PMP_ALLOFF_FASTPATH_EN: skip the scan when every entry is OFF.
module pmp_serial_checker #(
  parameter int unsigned PA_BITS     = 56,
  parameter int unsigned PMP_ENTRIES = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  pmp_serial_checker_if.slave                 bus,
  input  logic [8*PMP_ENTRIES-1:0]            PMPCfgArray,
  input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0]  PMPAdrArray
);

  localparam int unsigned AW    = PA_BITS - 2;
  localparam int unsigned IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;
  localparam logic [1:0] PRIV_M  = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               page_prev_q, page_prev_d;
  logic [PA_BITS-1:0] adr_q, adr_d;
  logic [1:0]         priv_q, priv_d;
  logic [2:0]         acc_q, acc_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_match_q, rsp_match_d;
  logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic               rsp_fault_q, rsp_fault_d;

  logic [7:0]    cfg_arr [PMP_ENTRIES];
  logic [AW-1:0] adr_arr [PMP_ENTRIES];

  for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_unpack
    assign cfg_arr[g] = PMPCfgArray[8*g +: 8];
    assign adr_arr[g] = PMPAdrArray[AW*g +: AW];
  end

  // Shared address-match datapath for the entry under evaluation.
  logic [7:0]         cfg_sel;
  logic [AW-1:0]      pmpadr_sel;
  logic [PA_BITS-1:0] base;
  logic [PA_BITS-1:0] mask;
  logic               below_top;
  logic               natural_hit;
  logic               entry_hit;
  logic               hit_fault;
  logic               unused_cfg_bits;

  assign cfg_sel         = cfg_arr[idx_q];
  assign pmpadr_sel      = adr_arr[idx_q];
  assign unused_cfg_bits = ^cfg_sel[6:5];
  assign base            = {pmpadr_sel, 2'b00};
  assign below_top       = adr_q < base;
  // NA4 adds nothing, so only the two byte-offset bits are masked.
  assign mask        = {(pmpadr_sel + AW'(cfg_sel[4:3] == A_NAPOT)) ^ pmpadr_sel, 2'b11};
  assign natural_hit = ((adr_q ^ base) & ~mask) == '0;
  assign hit_fault   = !((priv_q == PRIV_M) && !cfg_sel[7]) && !(|(acc_q & cfg_sel[2:0]));

  always_comb begin
    case (cfg_sel[4:3])
      A_TOR:          entry_hit = page_prev_q & below_top;
      A_NA4, A_NAPOT: entry_hit = natural_hit;
      default:        entry_hit = 1'b0;
    endcase
  end

`ifdef PMP_ALLOFF_FASTPATH_EN
  logic all_off;

  always_comb begin
    all_off = 1'b1;
    for (int i = 0; i < int'(PMP_ENTRIES); i++) begin
      if (cfg_arr[i][4:3] != 2'b00) all_off = 1'b0;
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    page_prev_d = page_prev_q;
    adr_d       = adr_q;
    priv_d      = priv_q;
    acc_d       = acc_q;
    rsp_match_d = rsp_match_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_fault_d = rsp_fault_q;

    case (state_q)
      IDLE: begin
        if (bus.ReqValid && !bus.Flush) begin
          adr_d       = bus.ReqAdr;
          priv_d      = bus.ReqPriv;
          acc_d       = bus.ReqAcc;
          idx_d       = '0;
          page_prev_d = 1'b1;
          state_d     = SCAN;
`ifdef PMP_ALLOFF_FASTPATH_EN
          if (all_off) begin
            state_d     = DONE;
            rsp_match_d = 1'b0;
            rsp_idx_d   = '0;
            rsp_fault_d = (bus.ReqPriv != PRIV_M);
          end
`endif
        end
      end
      SCAN: begin
        if (bus.Flush) begin
          state_d = IDLE;
        end else begin
          // Every entry, even OFF, becomes the lower bound for the next TOR.
          page_prev_d = ~below_top;
          if (entry_hit) begin
            state_d     = DONE;
            rsp_match_d = 1'b1;
            rsp_idx_d   = idx_q;
            rsp_fault_d = hit_fault;
          end else if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            rsp_match_d = 1'b0;
            rsp_idx_d   = '0;
            rsp_fault_d = (priv_q != PRIV_M);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.Flush || bus.RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      page_prev_q <= 1'b1;
      adr_q       <= '0;
      priv_q      <= '0;
      acc_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_match_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      page_prev_q <= page_prev_d;
      adr_q       <= adr_d;
      priv_q      <= priv_d;
      acc_q       <= acc_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_match_q <= rsp_match_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.ReqReady = req_ready_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspMatch = rsp_match_q;
  assign bus.RspIdx   = rsp_idx_q;
  assign bus.RspFault = rsp_fault_q;

endmodule
